// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences an external single-bit full-adder cell
// LSB first and assembles a WIDTH-bit sum with carry-out and signed overflow.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             ci_in,
  output logic             bit_a,
  output logic             bit_b,
  output logic             bit_ci,
  input  logic             bit_sum,
  input  logic             bit_co,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             co_out,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  // Only the bits gathered so far are kept; the incoming sum bit completes the word.
  logic [WIDTH-2:0]   s_sh_r;
  logic [WIDTH-1:0]   s_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               carry_r;
  logic [WIDTH-1:0]   sum_r;
  logic               co_r;
  logic               ovf_r;
  logic               busy_r;
  logic               done_r;
  logic               accept_s;
  logic               last_s;

  // Next-state decode and operand-accept / final-bit strobes.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    s_next_s = {bit_sum, s_sh_r};
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          last_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register with status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
    end
  end

  // Operand shifting, carry chaining and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      s_sh_r  <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      co_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      a_sh_r  <= a_in;
      b_sh_r  <= b_in;
      carry_r <= ci_in;
      cnt_r   <= '0;
    end else if (state_r == RUN) begin
      a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
      s_sh_r <= s_next_s[WIDTH-1:1];
      cnt_r  <= cnt_r + CNT_ONE;
      if (last_s) begin
        // carry_r here is the carry into the MSB; clearing it keeps bit_ci low once idle.
        sum_r   <= s_next_s;
        co_r    <= bit_co;
        ovf_r   <= carry_r ^ bit_co;
        carry_r <= 1'b0;
      end else begin
        carry_r <= bit_co;
      end
    end
  end

  // The operand shifters drain to zero over WIDTH shifts, so the cell drive is 0 outside RUN.
  assign bit_a   = a_sh_r[0];
  assign bit_b   = b_sh_r[0];
  assign bit_ci  = carry_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign sum_out = sum_r;
  assign co_out  = co_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with a behavioural addbit cell and an
// arithmetic reference model (a + b + ci in WIDTH+1 bits).
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         ci_in;
  logic         bit_a, bit_b, bit_ci, bit_sum, bit_co;
  logic         busy, done, co_out, ovf;
  logic [W-1:0] sum_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .ci_in(ci_in),
    .bit_a(bit_a), .bit_b(bit_b), .bit_ci(bit_ci), .bit_sum(bit_sum), .bit_co(bit_co),
    .busy(busy), .done(done), .sum_out(sum_out), .co_out(co_out), .ovf(ovf)
  );

  // Behavioural full-adder cell.
  assign bit_sum = bit_a ^ bit_b ^ bit_ci;
  assign bit_co  = (bit_a & bit_b) | (bit_ci & (bit_a ^ bit_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: {ovf, co, sum} from plain arithmetic and operand/result signs.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         v;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    s    = full[W-1:0];
    v    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {v, full[W], s};
  endfunction

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; ci_in = c;
    @(posedge clk);
    #1;
    start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); ci_in = 1'($urandom);
  endtask

  // Edges after the accept edge until done is seen (-1 on timeout).
  task automatic wait_done(output int n);
    bit got;
    got = 1'b0;
    n = 0;
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      got = done;
    end
    if (!got) n = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start = 1'b0; a_in = '0; b_in = '0; ci_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, co_out, ovf, bit_a, bit_b, bit_ci} !== 7'b0 || sum_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: got flags=%b sum=%h want flags=0000000 sum=00",
               {busy, done, co_out, ovf, bit_a, bit_b, bit_ci}, sum_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [5] = '{8'h0F, 8'hFF, 8'hFF, 8'h7F, 8'h80};
    logic [W-1:0] tb [5] = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h80};
    logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] es [5] = '{8'h10, 8'h00, 8'h00, 8'h80, 8'h00};
    logic         eco[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic         eov[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int n;
    for (int i = 0; i < 5; i++) begin
      launch(ta[i], tb[i], tc[i]);
      wait_done(n);
      total++;
      if (n !== W) begin
        bad++; $display("FAIL dir_latency[%0d]: got %0d edges want %0d", i, n, W);
      end
      total++;
      if ({sum_out, co_out, ovf} !== {es[i], eco[i], eov[i]}) begin
        bad++;
        $display("FAIL dir_result[%0d]: got sum=%h co=%b ovf=%b want sum=%h co=%b ovf=%b",
                 i, sum_out, co_out, ovf, es[i], eco[i], eov[i]);
      end
      @(negedge clk);
      total++;
      if ({done, busy, bit_a, bit_b, bit_ci} !== 5'b0) begin
        bad++;
        $display("FAIL dir_idle[%0d]: got done/busy/bits=%b want 00000", i,
                 {done, busy, bit_a, bit_b, bit_ci});
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    logic         c;
    logic [W+1:0] exp;
    int n;
    for (int i = 0; i < 25; i++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      exp = ref_add(a, b, c);
      launch(a, b, c);
      wait_done(n);
      total++;
      if (n !== W || {ovf, co_out, sum_out} !== exp) begin
        bad++;
        $display("FAIL rand[%0d] %h+%h+%b: got n=%0d ovf/co/sum=%h want n=%0d %h",
                 i, a, b, c, n, {ovf, co_out, sum_out}, W, exp);
      end
    end
  endtask

  task automatic test_ignored_start;
    logic [W-1:0] prev;
    logic [W+1:0] exp;
    int n;
    launch(8'h2C, 8'h9D, 1'b0);
    wait_done(n);
    prev = ref_add(8'h2C, 8'h9D, 1'b0);
    exp  = ref_add(8'h21, 8'h13, 1'b0);
    launch(8'h21, 8'h13, 1'b0);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || sum_out !== prev[W-1:0]) begin
        bad++;
        $display("FAIL ign_run[%0d]: got busy=%b done=%b sum=%h want busy=1 done=0 sum=%h",
                 k, busy, done, sum_out, prev[W-1:0]);
      end
      if (k == 3) begin
        start = 1'b1; a_in = 8'h55; b_in = 8'h55;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || {ovf, co_out, sum_out} !== exp) begin
      bad++;
      $display("FAIL ign_result: got done=%b ovf/co/sum=%h want done=1 %h",
               done, {ovf, co_out, sum_out}, exp);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL ign_not_queued: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    int n1, n2, t1, t2;
    @(negedge clk);
    start = 1'b1; a_in = 8'h12; b_in = 8'h34; ci_in = 1'b0;
    @(posedge clk);
    #1;
    a_in = 8'hA0; b_in = 8'h60;
    wait_done(n1);
    t1 = cyc;
    total++;
    if (n1 !== W || sum_out !== 8'h46 || co_out !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first: got n=%0d sum=%h co=%b want n=%0d sum=46 co=0",
               n1, sum_out, co_out, W);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n2);
    t2 = cyc;
    total++;
    if (n2 !== W || t2 - t1 !== W + 1) begin
      bad++;
      $display("FAIL b2b_spacing: got n=%0d gap=%0d want n=%0d gap=%0d", n2, t2 - t1, W, W + 1);
    end
    total++;
    if (sum_out !== 8'h00 || co_out !== 1'b1) begin
      bad++; $display("FAIL b2b_second: got sum=%h co=%b want sum=00 co=1", sum_out, co_out);
    end
  endtask

  task automatic test_reset_abort;
    int  n;
    bit  saw_done;
    launch(8'h33, 8'h11, 1'b0);
    wait_done(n);
    total++;
    if (n !== W || sum_out !== 8'h44) begin
      bad++; $display("FAIL abort_pre: got n=%0d sum=%h want n=%0d sum=44", n, sum_out, W);
    end
    launch(8'hC3, 8'h5A, 1'b1);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sum_out !== 8'h00 || bit_a !== 1'b0) begin
      bad++;
      $display("FAIL abort_async: got busy=%b done=%b sum=%h bit_a=%b want 0 0 00 0",
               busy, done, sum_out, bit_a);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    total++;
    if (saw_done !== 1'b0) begin
      bad++; $display("FAIL abort_no_done: got done seen=%b want 0", saw_done);
    end
    launch(8'h01, 8'h01, 1'b0);
    wait_done(n);
    total++;
    if (n !== W || {sum_out, co_out, ovf} !== {8'h02, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL abort_fresh: got n=%0d sum=%h co=%b ovf=%b want n=%0d sum=02 co=0 ovf=0",
               n, sum_out, co_out, ovf, W);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
